// File: rtl/mc_rsp_model.sv
// mc_rsp_model: single-port MC responder.
// It accepts RD8/WR8 requests into a word-addressed 64-bit memory. Each accepted
// request is queued with an 8-bit timestamp. The head of the queue issues once it
// is LAT cycles old, provided response backpressure was low. Responses are in order.
//
// Ports
//   clk, i_reset             core clock, synchronous active-high reset
//   mc_rq_*                  request channel (vld/cmd/scmd/vadr/size/rtnctl/data)
//   mc_rq_stall              registered request backpressure (occupancy >= DEPTH-2)
//   mc_rq_flush              write-flush request pulse
//   mc_rs_flush_cmplt        flush-complete pulse
//   mc_rs_*                  response channel (vld/cmd/scmd/data/rtnctl), stall input
//   err_ovfl, err_cmd        sticky error flags
//   rd_cnt, wr_cnt           accepted RD8/WR8 counts
module mc_rsp_model #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 16,
    parameter int LAT          = 8
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [1:0]              mc_rq_size,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]             mc_rq_data,
    output logic                    mc_rq_stall,
    input  logic                    mc_rq_flush,
    output logic                    mc_rs_flush_cmplt,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    output logic                    err_ovfl,
    output logic                    err_cmd,
    output logic [31:0]             rd_cnt,
    output logic [31:0]             wr_cnt
);
    localparam int           PTR_W     = $clog2(DEPTH);
    localparam int           MEM_WORDS = 1 << ADDR_W;
    localparam logic [2:0]   CMD_RD8   = 3'd1;
    localparam logic [2:0]   CMD_WR8   = 3'd2;
    localparam logic [2:0]   RS_RDATA  = 3'd2;
    localparam logic [2:0]   RS_WCMPLT = 3'd3;
    localparam logic [PTR_W:0] FULL_LVL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(DEPTH - 2);
    // The issue decision is made one cycle before mc_rs_vld rises (registered
    // outputs), so the head must be LAT-1 cycles old at decision time.
    localparam logic [7:0]   AGE_MIN   = 8'(LAT - 1);

    typedef enum logic {FL_IDLE, FL_WAIT} flush_state_t;

    // Backing store and response queue storage (no reset: contents survive reset)
    logic [63:0]             mem [MEM_WORDS];
    logic [63:0]             mem_rdata_q;
    logic                    is_rd_arr  [DEPTH];
    logic [3:0]              scmd_arr   [DEPTH];
    logic [RTNCTL_WIDTH-1:0] rtnctl_arr [DEPTH];
    logic [7:0]              ts_arr     [DEPTH];
    logic [63:0]             data_arr   [DEPTH];

    // Control state
    logic [7:0]              ts_q, ts_d;
    logic [PTR_W:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    pend_vld_q, pend_vld_d, pend_rd_q, pend_rd_d;
    logic [PTR_W-1:0]        pend_idx_q, pend_idx_d;
    logic                    rq_stall_q, rq_stall_d;
    logic                    rs_vld_q, rs_vld_d;
    logic [2:0]              rs_cmd_q, rs_cmd_d;
    logic [3:0]              rs_scmd_q, rs_scmd_d;
    logic [63:0]             rs_data_q, rs_data_d;
    logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
    logic                    err_ovfl_q, err_ovfl_d, err_cmd_q, err_cmd_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    flush_state_t            fl_state_q, fl_state_d;
    logic                    flush_cmplt_q, flush_cmplt_d;

    // Request decode
    logic [ADDR_W-1:0]       word_idx;
    logic [2:0]              byte_off;
    logic [3:0]              lane_end;
    logic [7:0]              byte_en;
    logic                    cmd_legal, is_rd, rq_legal, push, pop, mem_we;
    logic [7:0]              head_age;
    logic [63:0]             pend_word, head_data;
    logic                    unused_vadr_hi;

    assign word_idx       = mc_rq_vadr[ADDR_W+2:3];
    assign byte_off       = mc_rq_vadr[2:0];
    assign unused_vadr_hi = ^mc_rq_vadr[47:ADDR_W+3];
    // One past the last addressed lane; lanes beyond 7 fall outside the word.
    assign lane_end       = {1'b0, byte_off} + (4'd1 << mc_rq_size);

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign byte_en[gi] = (4'(gi) >= {1'b0, byte_off}) && (4'(gi) < lane_end);
    end

    always_comb begin
        cmd_legal = (mc_rq_cmd == CMD_RD8) || (mc_rq_cmd == CMD_WR8);
        is_rd     = (mc_rq_cmd == CMD_RD8);
        head_age  = ts_q - ts_arr[rd_ptr_q];
        pop       = !i_reset && (cnt_q != '0) && (head_age >= AGE_MIN) && !mc_rs_stall;
        rq_legal  = !i_reset && mc_rq_vld && cmd_legal;
        // A pop in the same cycle frees a slot, so a full queue still accepts.
        push      = rq_legal && ((cnt_q != FULL_LVL) || pop);
        mem_we    = push && !is_rd;
        // Read data reaches the queue one cycle after acceptance. If that entry
        // is already the head being issued, bypass the registered read word.
        pend_word = pend_rd_q ? mem_rdata_q : 64'd0;
        head_data = (pend_vld_q && (pend_idx_q == rd_ptr_q)) ? pend_word : data_arr[rd_ptr_q];
    end

    always_comb begin
        ts_d        = ts_q + 8'd1;
        cnt_d       = cnt_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        pend_vld_d  = push;
        pend_rd_d   = push && is_rd;
        pend_idx_d  = wr_ptr_q;
        rq_stall_d  = (cnt_d >= STALL_LVL);
        rs_vld_d    = pop;
        rs_cmd_d    = pop ? (is_rd_arr[rd_ptr_q] ? RS_RDATA : RS_WCMPLT) : 3'd0;
        rs_scmd_d   = pop ? scmd_arr[rd_ptr_q] : 4'd0;
        rs_data_d   = pop ? head_data : 64'd0;
        rs_rtnctl_d = pop ? rtnctl_arr[rd_ptr_q] : '0;
        err_ovfl_d  = err_ovfl_q || (rq_legal && !push);
        err_cmd_d   = err_cmd_q || (mc_rq_vld && !cmd_legal);
        rd_cnt_d    = (push && is_rd) ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d    = (push && !is_rd) ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    // Flush FSM. A flush that finds the queue already drained completes
    // straight from IDLE so the pulse lands in the next cycle.
    always_comb begin
        fl_state_d    = fl_state_q;
        flush_cmplt_d = 1'b0;
        case (fl_state_q)
            FL_IDLE: begin
                if (mc_rq_flush) begin
                    if ((cnt_q == '0) && !push) flush_cmplt_d = 1'b1;
                    else                        fl_state_d    = FL_WAIT;
                end
            end
            FL_WAIT: begin
                if ((cnt_q == '0) && !push) begin
                    flush_cmplt_d = 1'b1;
                    fl_state_d    = FL_IDLE;
                end
            end
            default: fl_state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            ts_q          <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pend_vld_q    <= 1'b0;
            pend_rd_q     <= 1'b0;
            pend_idx_q    <= '0;
            rq_stall_q    <= 1'b0;
            rs_vld_q      <= 1'b0;
            rs_cmd_q      <= '0;
            rs_scmd_q     <= '0;
            rs_data_q     <= '0;
            rs_rtnctl_q   <= '0;
            err_ovfl_q    <= 1'b0;
            err_cmd_q     <= 1'b0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            fl_state_q    <= FL_IDLE;
            flush_cmplt_q <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pend_vld_q    <= pend_vld_d;
            pend_rd_q     <= pend_rd_d;
            pend_idx_q    <= pend_idx_d;
            rq_stall_q    <= rq_stall_d;
            rs_vld_q      <= rs_vld_d;
            rs_cmd_q      <= rs_cmd_d;
            rs_scmd_q     <= rs_scmd_d;
            rs_data_q     <= rs_data_d;
            rs_rtnctl_q   <= rs_rtnctl_d;
            err_ovfl_q    <= err_ovfl_d;
            err_cmd_q     <= err_cmd_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            fl_state_q    <= fl_state_d;
            flush_cmplt_q <= flush_cmplt_d;
        end
    end

    // Memory: read-before-write registered port; byte-lane writes.
    always_ff @(posedge clk) begin
        mem_rdata_q <= mem[word_idx];
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= mc_rq_data[8*b +: 8];
            end
        end
    end

    // Queue storage: metadata at acceptance, data column one cycle later.
    always_ff @(posedge clk) begin
        if (push) begin
            is_rd_arr[wr_ptr_q]  <= is_rd;
            scmd_arr[wr_ptr_q]   <= mc_rq_scmd;
            rtnctl_arr[wr_ptr_q] <= mc_rq_rtnctl;
            ts_arr[wr_ptr_q]     <= ts_q;
        end
        if (pend_vld_q) data_arr[pend_idx_q] <= pend_word;
    end

    assign mc_rq_stall       = rq_stall_q;
    assign mc_rs_flush_cmplt = flush_cmplt_q;
    assign mc_rs_vld         = rs_vld_q;
    assign mc_rs_cmd         = rs_cmd_q;
    assign mc_rs_scmd        = rs_scmd_q;
    assign mc_rs_data        = rs_data_q;
    assign mc_rs_rtnctl      = rs_rtnctl_q;
    assign err_ovfl          = err_ovfl_q;
    assign err_cmd           = err_cmd_q;
    assign rd_cnt            = rd_cnt_q;
    assign wr_cnt            = wr_cnt_q;

endmodule

// File: tb/tb_mc_rsp_model.sv
// Scoreboard bench for mc_rsp_model: directed requests push expected responses,
// a negedge monitor pops and compares each response and flush-complete pulse.
module tb_mc_rsp_model;
    localparam int RTNCTL_WIDTH = 32;
    localparam int ADDR_W       = 10;
    localparam int DEPTH        = 16;
    localparam int LAT          = 8;
    localparam logic [2:0]  RD  = 3'd1;
    localparam logic [2:0]  WR  = 3'd2;
    localparam logic [63:0] W_PART = 64'hFFFF_FFFF_EEFF_FFFF;
    localparam logic [63:0] W40    = 64'h1234_FFFF_EEFF_FFFF;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        mc_rq_vld;
    logic [2:0]  mc_rq_cmd;
    logic [3:0]  mc_rq_scmd;
    logic [47:0] mc_rq_vadr;
    logic [1:0]  mc_rq_size;
    logic [31:0] mc_rq_rtnctl;
    logic [63:0] mc_rq_data;
    logic        mc_rq_stall;
    logic        mc_rq_flush;
    logic        mc_rs_flush_cmplt;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [3:0]  mc_rs_scmd;
    logic [63:0] mc_rs_data;
    logic [31:0] mc_rs_rtnctl;
    logic        mc_rs_stall;
    logic        err_ovfl;
    logic        err_cmd;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    mc_rsp_model #(
        .RTNCTL_WIDTH(RTNCTL_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)
    ) dut (
        .clk(clk), .i_reset(i_reset),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
        .mc_rq_data(mc_rq_data), .mc_rq_stall(mc_rq_stall), .mc_rq_flush(mc_rq_flush),
        .mc_rs_flush_cmplt(mc_rs_flush_cmplt), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
        .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl),
        .mc_rs_stall(mc_rs_stall), .err_ovfl(err_ovfl), .err_cmd(err_cmd),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [31:0] tag;
        logic [63:0] data;
        int          due;
        bit          exact;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cmplt_cnt    = 0;
    int   flush_exp_cyc = -1;
    bit   flush_wait   = 1'b0;
    bit   prev_rs_stall = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [47:0] adr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [31:0] tag,
                         input logic [63:0] exp_data, input bit exact, input bit expect_rsp);
        exp_t e;
        mc_rq_vld    = 1'b1;
        mc_rq_cmd    = cmd;
        mc_rq_vadr   = adr;
        mc_rq_size   = size;
        mc_rq_data   = wdata;
        mc_rq_rtnctl = tag;
        mc_rq_scmd   = tag[3:0];
        if (expect_rsp) begin
            e.cmd   = (cmd == RD) ? 3'd2 : 3'd3;
            e.scmd  = tag[3:0];
            e.tag   = tag;
            e.data  = exp_data;
            e.due   = cyc + LAT;
            e.exact = exact;
            sb.push_back(e);
        end
        $display("[TB] cyc %0d issue cmd=%0d vadr=0x%0h size=%0d tag=0x%0h", cyc, cmd, adr, size, tag);
        step();
        mc_rq_vld = 1'b0;
        mc_rq_cmd = 3'd0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: one line per response, compared against the scoreboard head.
    always @(negedge clk) begin
        if (i_reset) begin
            prev_rs_stall = 1'b0;
        end else begin
            if (mc_rs_flush_cmplt) begin
                cmplt_cnt++;
                $display("[TB] cyc %0d flush_cmplt", cyc);
                if (flush_exp_cyc < 0) chk("unexpected_cmplt", 64'(mc_rs_flush_cmplt), 64'd0);
                else begin
                    chk("cmplt_cycle", 64'(cyc), 64'(flush_exp_cyc));
                    flush_exp_cyc = -1;
                end
            end
            if (mc_rs_vld) begin
                $display("[TB] cyc %0d rsp cmd=%0d scmd=%0d tag=0x%0h data=0x%0h",
                         cyc, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data);
                chk("rsp_after_stall", 64'(prev_rs_stall), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(mc_rs_vld), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_cmd", 64'(mc_rs_cmd), 64'(mon_e.cmd));
                    chk("rsp_scmd", 64'(mc_rs_scmd), 64'(mon_e.scmd));
                    chk("rsp_tag", 64'(mc_rs_rtnctl), 64'(mon_e.tag));
                    chk("rsp_data", mc_rs_data, mon_e.data);
                    if (mon_e.exact) chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                    else             chk("rsp_not_early", 64'(cyc >= mon_e.due), 64'd1);
                    if (flush_wait && sb.size() == 0) begin
                        flush_exp_cyc = cyc + 1;
                        flush_wait    = 1'b0;
                    end
                end
            end
            prev_rs_stall = mc_rs_stall;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        bit  saw_stall;
        i_reset = 1'b1; mc_rq_vld = 1'b0; mc_rq_cmd = 3'd0; mc_rq_scmd = 4'd0;
        mc_rq_vadr = '0; mc_rq_size = 2'd0; mc_rq_rtnctl = '0; mc_rq_data = '0;
        mc_rq_flush = 1'b0; mc_rs_stall = 1'b0;
        repeat (3) step();
        chk("rst_rs_vld", 64'(mc_rs_vld), 64'd0);
        chk("rst_rq_stall", 64'(mc_rq_stall), 64'd0);
        chk("rst_cmplt", 64'(mc_rs_flush_cmplt), 64'd0);
        chk("rst_errs", 64'({err_ovfl, err_cmd}), 64'd0);
        chk("rst_cnts", {rd_cnt, wr_cnt}, 64'd0);
        i_reset = 1'b0;
        step();

        // Write then read back, exact latency
        issue(WR, 48'h40, 2'd3, 64'h1122_3344_5566_7788, 32'hA5, 64'd0, 1'b1, 1'b1);
        issue(RD, 48'h40, 2'd3, 64'd0, 32'h5A, 64'h1122_3344_5566_7788, 1'b1, 1'b1);
        drain("drain_basic");
        chk("wr_cnt_basic", 64'(wr_cnt), 64'd1);
        chk("rd_cnt_basic", 64'(rd_cnt), 64'd1);

        // Partial, misaligned and aliased accesses
        issue(WR, 48'h40, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32'h11, 64'd0, 1'b1, 1'b1);
        issue(WR, 48'h43, 2'd0, 64'h0000_0000_EE00_0000, 32'h12, 64'd0, 1'b1, 1'b1);
        issue(RD, 48'h40, 2'd3, 64'd0, 32'h13, W_PART, 1'b1, 1'b1);
        issue(WR, 48'h46, 2'd2, 64'h1234_0000_0000_0000, 32'h14, 64'd0, 1'b1, 1'b1);
        issue(RD, 48'h40, 2'd3, 64'd0, 32'h15, W40, 1'b1, 1'b1);
        issue(RD, 48'h40 + (48'd1 << (ADDR_W + 3)), 2'd3, 64'd0, 32'h16, W40, 1'b1, 1'b1);
        issue(RD, 48'h41, 2'd0, 64'd0, 32'h17, W40, 1'b1, 1'b1);
        drain("drain_partial");
        chk("wr_cnt_partial", 64'(wr_cnt), 64'd4);
        chk("rd_cnt_partial", 64'(rd_cnt), 64'd5);

        // 20 reads obeying mc_rq_stall while responses are held off
        mc_rs_stall = 1'b1;
        sent = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 80 && sent < 20; i++) begin
            if (i == 30) mc_rs_stall = 1'b0;
            if (!mc_rq_stall) begin
                issue(RD, 48'h40, 2'd3, 64'd0, 32'h100 + 32'(sent), W40, 1'b0, 1'b1);
                sent++;
            end else begin
                if (!saw_stall) begin
                    chk("rq_stall_occupancy", 64'(sb.size()), 64'(DEPTH - 2));
                    saw_stall = 1'b1;
                end
                step();
            end
        end
        mc_rs_stall = 1'b0;
        chk("rq_stall_seen", 64'(saw_stall), 64'd1);
        chk("burst_sent", 64'(sent), 64'd20);
        chk("burst_no_ovfl", 64'(err_ovfl), 64'd0);
        drain("drain_burst");
        chk("rd_cnt_burst", 64'(rd_cnt), 64'd25);

        // 17 outstanding ignoring stall: the 17th is dropped
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 17; i++)
            issue(RD, 48'h40, 2'd3, 64'd0, 32'h200 + 32'(i), W40, 1'b0, i < 16);
        chk("ovfl_set", 64'(err_ovfl), 64'd1);
        chk("rd_cnt_ovfl", 64'(rd_cnt), 64'd41);
        mc_rs_stall = 1'b0;
        drain("drain_ovfl");

        // Response stall held over eligible responses
        for (int i = 0; i < 6; i++)
            issue(RD, 48'h40, 2'd3, 64'd0, 32'h300 + 32'(i), W40, 1'b0, 1'b1);
        for (int i = 0; i < 20 && sb.size() == 6; i++) step();
        mc_rs_stall = 1'b1;
        repeat (10) step();
        mc_rs_stall = 1'b0;
        drain("drain_rs_stall");
        chk("err_ovfl_sticky", 64'(err_ovfl), 64'd1);

        // Flush behind three writes, with an extra pulse absorbed while waiting
        issue(WR, 48'h80, 2'd3, 64'hA, 32'h401, 64'd0, 1'b1, 1'b1);
        issue(WR, 48'h88, 2'd3, 64'hB, 32'h402, 64'd0, 1'b1, 1'b1);
        issue(WR, 48'h90, 2'd3, 64'hC, 32'h403, 64'd0, 1'b1, 1'b1);
        mc_rq_flush = 1'b1;
        flush_wait  = 1'b1;
        step();
        mc_rq_flush = 1'b0;
        step();
        mc_rq_flush = 1'b1;
        step();
        mc_rq_flush = 1'b0;
        drain("drain_flush");
        repeat (3) step();
        chk("cmplt_count_busy", 64'(cmplt_cnt), 64'd1);
        chk("flush_wait_done", 64'(flush_wait), 64'd0);

        // Flush with the queue idle
        flush_exp_cyc = cyc + 1;
        mc_rq_flush = 1'b1;
        step();
        mc_rq_flush = 1'b0;
        repeat (2) step();
        chk("cmplt_count_idle", 64'(cmplt_cnt), 64'd2);

        // Illegal command
        issue(3'd5, 48'h40, 2'd3, 64'd0, 32'h500, 64'd0, 1'b0, 1'b0);
        chk("err_cmd_set", 64'(err_cmd), 64'd1);
        repeat (12) step();
        chk("cnts_after_illegal", {rd_cnt, wr_cnt}, {32'd47, 32'd7});

        // Reset with four requests in flight
        for (int i = 0; i < 4; i++)
            issue(RD, 48'h40, 2'd3, 64'd0, 32'h600 + 32'(i), W40, 1'b0, 1'b1);
        i_reset = 1'b1;
        sb.delete();
        repeat (2) step();
        i_reset = 1'b0;
        step();
        chk("post_rst_vld", 64'(mc_rs_vld), 64'd0);
        chk("post_rst_data", mc_rs_data, 64'd0);
        chk("post_rst_errs", 64'({err_ovfl, err_cmd, mc_rq_stall}), 64'd0);
        chk("post_rst_cnts", {rd_cnt, wr_cnt}, 64'd0);
        repeat (12) step();
        issue(RD, 48'h40, 2'd3, 64'd0, 32'h700, W40, 1'b1, 1'b1);
        drain("drain_post_rst");
        chk("rd_cnt_post_rst", 64'(rd_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
